spi_master_io: RTL and testbench

//  SPI master IO state machine; the initiating end of the SPI slave IO link.

---
 rtl/spi_master_io_pkg.sv | 39 +++
 rtl/spi_master_clkgen.sv | 48 ++++
 rtl/spi_master_io.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_master_io.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_io_pkg.sv
// Shared encodings, widths and helpers for the SPI master IO block.
// The state encodings and command codes are common with the SPI slave IO side.
package spi_master_io_pkg;

    localparam int unsigned SPI_DW  = 64;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned SIZE_W  = 4;
    localparam int unsigned DIV_W   = 8;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] SPI_M_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] SPI_M_SETUP = 3'd1;
    localparam logic [STATE_W-1:0] SPI_M_SHIFT = 3'd2;
    localparam logic [STATE_W-1:0] SPI_M_HOLD  = 3'd3;
    localparam logic [STATE_W-1:0] SPI_M_GAP   = 3'd4;

    localparam logic [7:0] SPI_WR    = 8'h02;
    localparam logic [7:0] SPI_RD    = 8'h03;
    localparam logic [7:0] SPI_FETCH = 8'h0B;

    // Transfer configuration captured at accept time.
    typedef struct packed {
        logic             cpol;
        logic             cpha;
        logic             lsbfirst;
        logic [DIV_W-1:0] clkdiv;
    } spi_cfg_t;

    // Position of the idx-th transmitted bit within its byte.
    function automatic logic [2:0] bit_pos(input logic lsbfirst, input logic [2:0] idx);
        return lsbfirst ? idx : 3'(3'd7 - idx);
    endfunction

    function automatic logic size_legal(input logic [SIZE_W-1:0] size,
                                        input int unsigned max_bytes);
        return (size != '0) && (32'(size) <= max_bytes);
    endfunction

endpackage

// File: rtl/spi_master_clkgen.sv
// Half-period divider for the SPI master: produces sclk and marks the
// clk cycle on which the next leading or trailing sclk edge is launched.
module spi_master_clkgen
    import spi_master_io_pkg::*;
(
    input  logic             clk,
    input  logic             nreset,
    input  logic             restart_i,
    input  logic             run_i,
    input  logic             cpol_i,
    input  logic [DIV_W-1:0] clkdiv_i,
    output logic             tick_c,
    output logic             lead_c,
    output logic             trail_c,
    output logic             sclk_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    // A half-period ends on the cycle the counter reaches clkdiv.
    assign tick_c  = (cnt_q == clkdiv_i);
    assign lead_c  = run_i && tick_c && (sclk_q == cpol_i);
    assign trail_c = run_i && tick_c && (sclk_q != cpol_i);
    assign sclk_o  = sclk_q;

    always_comb begin
        cnt_d  = cnt_q + DIV_W'(1);
        sclk_d = cpol_i;
        if (restart_i || tick_c) begin
            cnt_d = '0;
        end
        if (run_i) begin
            sclk_d = tick_c ? ~sclk_q : sclk_q;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_io.sv
// SPI master IO: accepts 1..8 byte full-duplex transfers and drives ss/sclk/mosi.
// Build option SPI_MASTER_RX_EN: capture miso into rx_data; otherwise rx_data is 0.
module spi_master_io
    import spi_master_io_pkg::*;
#(
    parameter int unsigned DW = SPI_DW
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              spi_en,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsbfirst,
    input  logic [DIV_W-1:0]  clkdiv,
    input  logic              access_in,
    input  logic [DW-1:0]     tx_data,
    input  logic [SIZE_W-1:0] tx_size,
    output logic              wait_out,
    output logic              access_out,
    output logic [DW-1:0]     rx_data,
    output logic              ss,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned IDX_W     = $clog2(DW);
    localparam int unsigned EDGE_W    = IDX_W + 1;
    localparam int unsigned MAX_BYTES = DW / BYTE_W;

    logic [STATE_W-1:0] state_q, state_d;
    spi_cfg_t           cfg_q, cfg_d;
    logic [SIZE_W-1:0]  size_q, size_d;
    logic [DW-1:0]      tx_q, tx_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;
    logic               ss_q, ss_d;
    logic               mosi_q, mosi_d;
    logic               wait_q, wait_d;
    logic               done_q, done_d;

    logic               restart_c, run_c, cpol_c;
    logic               tick_c, lead_c, trail_c;
    logic [EDGE_W-1:0]  last_edge_c;
    logic [IDX_W-1:0]   bit_c, next_bit_c;
    logic               sample_c;

`ifdef SPI_MASTER_RX_EN
    logic [DW-1:0]      rx_q, rx_d;
    logic [DW-1:0]      rx_data_q, rx_data_d;
`else
    logic               miso_unused_c;
    assign miso_unused_c = miso;
`endif

    // Map a serial bit sequence number onto its position in the data word.
    function automatic logic [IDX_W-1:0] bit_index(input logic lsb, input logic [IDX_W-1:0] seq);
        return {seq[IDX_W-1:3], bit_pos(lsb, seq[2:0])};
    endfunction

    assign run_c       = (state_q == SPI_M_SHIFT) && spi_en;
    assign cpol_c      = (state_q == SPI_M_IDLE) ? cpol : cfg_q.cpol;
    assign last_edge_c = EDGE_W'({size_q, 4'b0000} - (SIZE_W + 4)'(1));
    assign bit_c       = edge_q[EDGE_W-1:1];
    assign next_bit_c  = bit_c + IDX_W'(1);
    assign sample_c    = cfg_q.cpha ? trail_c : lead_c;

    spi_master_clkgen u_clkgen (
        .clk       (clk),
        .nreset    (nreset),
        .restart_i (restart_c),
        .run_i     (run_c),
        .cpol_i    (cpol_c),
        .clkdiv_i  (cfg_q.clkdiv),
        .tick_c    (tick_c),
        .lead_c    (lead_c),
        .trail_c   (trail_c),
        .sclk_o    (sclk)
    );

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        size_d    = size_q;
        tx_d      = tx_q;
        edge_d    = edge_q;
        ss_d      = ss_q;
        mosi_d    = mosi_q;
        wait_d    = wait_q;
        done_d    = 1'b0;
        restart_c = 1'b0;
`ifdef SPI_MASTER_RX_EN
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
`endif

        if ((state_q != SPI_M_IDLE) && !spi_en) begin
            // Abort: release the bus at once and drop the transfer silently.
            state_d   = SPI_M_IDLE;
            ss_d      = 1'b1;
            mosi_d    = 1'b0;
            wait_d    = 1'b0;
            restart_c = 1'b1;
        end else begin
            case (state_q)
                SPI_M_IDLE: begin
                    if (access_in && spi_en && !wait_q && size_legal(tx_size, MAX_BYTES)) begin
                        state_d   = SPI_M_SETUP;
                        cfg_d     = '{cpol: cpol, cpha: cpha, lsbfirst: lsbfirst, clkdiv: clkdiv};
                        size_d    = tx_size;
                        tx_d      = tx_data;
                        edge_d    = '0;
                        ss_d      = 1'b0;
                        wait_d    = 1'b1;
                        restart_c = 1'b1;
                        mosi_d    = cpha ? 1'b0 : tx_data[bit_index(lsbfirst, '0)];
`ifdef SPI_MASTER_RX_EN
                        rx_d      = '0;
`endif
                    end
                end
                SPI_M_SETUP: begin
                    if (tick_c) begin
                        state_d   = SPI_M_SHIFT;
                        restart_c = 1'b1;
                    end
                end
                SPI_M_SHIFT: begin
                    if (lead_c || trail_c) begin
                        edge_d = edge_q + EDGE_W'(1);
                        if (lead_c && cfg_q.cpha) begin
                            mosi_d = tx_q[bit_index(cfg_q.lsbfirst, bit_c)];
                        end
                        if (trail_c && !cfg_q.cpha) begin
                            mosi_d = tx_q[bit_index(cfg_q.lsbfirst, next_bit_c)];
                        end
`ifdef SPI_MASTER_RX_EN
                        if (sample_c) begin
                            rx_d[bit_index(cfg_q.lsbfirst, bit_c)] = miso;
                        end
`endif
                        if (edge_q == last_edge_c) begin
                            state_d   = SPI_M_HOLD;
                            mosi_d    = 1'b0;
                            restart_c = 1'b1;
                        end
                    end
                end
                SPI_M_HOLD: begin
                    if (tick_c) begin
                        state_d   = SPI_M_GAP;
                        ss_d      = 1'b1;
                        restart_c = 1'b1;
                    end
                end
                SPI_M_GAP: begin
                    if (tick_c) begin
                        state_d   = SPI_M_IDLE;
                        wait_d    = 1'b0;
                        done_d    = 1'b1;
                        restart_c = 1'b1;
`ifdef SPI_MASTER_RX_EN
                        rx_data_d = rx_q;
`endif
                    end
                end
                default: begin
                    state_d = SPI_M_IDLE;
                    ss_d    = 1'b1;
                    wait_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= SPI_M_IDLE;
            cfg_q   <= '0;
            size_q  <= '0;
            tx_q    <= '0;
            edge_q  <= '0;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
            wait_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            size_q  <= size_d;
            tx_q    <= tx_d;
            edge_q  <= edge_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
        end
    end

`ifdef SPI_MASTER_RX_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_q      <= '0;
            rx_data_q <= '0;
        end else begin
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign rx_data = rx_data_q;
`else
    assign rx_data = '0;
`endif

    assign ss         = ss_q;
    assign mosi       = mosi_q;
    assign wait_out   = wait_q;
    assign access_out = done_q;

endmodule

// File: tb/tb_spi_master_io.sv
// Randomized bench for spi_master_io: an SPI slave model exchanges bytes with
// the master and every completed or aborted transfer is scored against it.
module tb_spi_master_io;

    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          nreset, spi_en, cpol, cpha, lsbfirst, access_in, loopback;
    logic [7:0]    clkdiv;
    logic [DW-1:0] tx_data;
    logic [3:0]    tx_size;
    logic          wait_out, access_out, ss, sclk, mosi, miso;
    logic [DW-1:0] rx_data;

    int errors = 0;
    int checks = 0;

    // Slave model configuration (written by the stimulus) and state (written by the model).
    logic          s_cpha, s_lsb;
    int            s_n;
    logic [63:0]   s_data;
    logic [63:0]   s_got = '0;
    int            s_edges = 0;
    logic          miso_m = 1'b0;
    logic          ss_prev = 1'b1, sclk_prev = 1'b0, mosi_prev = 1'b0;
    logic [63:0]   last_rx = '0;

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : miso_m;

    spi_master_io dut (
        .clk        (clk),
        .nreset     (nreset),
        .spi_en     (spi_en),
        .cpol       (cpol),
        .cpha       (cpha),
        .lsbfirst   (lsbfirst),
        .clkdiv     (clkdiv),
        .access_in  (access_in),
        .tx_data    (tx_data),
        .tx_size    (tx_size),
        .wait_out   (wait_out),
        .access_out (access_out),
        .rx_data    (rx_data),
        .ss         (ss),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bit j of the serial stream lives in byte j/8 at an order-dependent position.
    function automatic int pos(input int j, input logic lsb);
        return (j / 8) * 8 + (lsb ? (j % 8) : (7 - (j % 8)));
    endfunction

    function automatic logic [63:0] byte_mask(input int n);
        logic [63:0] one;
        one = 64'd1;
        return (n >= 8) ? '1 : ((one << (8 * n)) - 64'd1);
    endfunction

    // SPI slave: counts sclk edges while selected, samples/drives per cpha.
    always @(negedge clk) begin
        if (ss_prev && !ss) begin
            s_edges = 0;
            s_got   = '0;
            if (!s_cpha) miso_m = s_data[pos(0, s_lsb)];
        end else if (!ss && !ss_prev && (sclk != sclk_prev)) begin
            s_edges++;
            if (s_edges % 2 == 1) begin
                if (s_cpha) miso_m = s_data[pos((s_edges - 1) / 2, s_lsb)];
                else        s_got[pos((s_edges - 1) / 2, s_lsb)] = mosi_prev;
            end else begin
                if (s_cpha)                      s_got[pos(s_edges / 2 - 1, s_lsb)] = mosi_prev;
                else if (s_edges / 2 < 8 * s_n)  miso_m = s_data[pos(s_edges / 2, s_lsb)];
            end
        end
        ss_prev   = ss;
        sclk_prev = sclk;
        mosi_prev = mosi;
    end

    // mode: 0 normal, 1 drop spi_en at cycle 'at', 2 reset at 'at', 3 extra request at 'at'.
    task automatic xfer(input logic cp, input logic ch, input logic lsb, input logic [7:0] div,
                        input int n, input logic [63:0] tx, input logic [63:0] sd,
                        input logic loop, input int mode, input int at);
        int          lat, cyc, pulses;
        logic [63:0] exp_rx;
        lat = 1 + (int'(div) + 1) * (3 + 16 * n);
        @(negedge clk);
        cpol = cp; cpha = ch; lsbfirst = lsb; clkdiv = div;
        tx_size = 4'(n); tx_data = tx; access_in = 1'b1;
        s_cpha = ch; s_lsb = lsb; s_n = n; s_data = sd; loopback = loop;
        @(negedge clk);
        cyc = 1;
        access_in = 1'b0;
        check("wait_hi", 64'(wait_out), 64'd1);
        tx_data  = {$urandom, $urandom};
        tx_size  = 4'($urandom);
        clkdiv   = 8'($urandom);
        lsbfirst = 1'($urandom);
        cpha     = 1'($urandom);
        while (access_out !== 1'b1 && cyc < lat + 20) begin
            if (mode == 1 && cyc == at) begin
                spi_en = 1'b0;
                @(negedge clk);
                check("abort_pins", 64'({ss, sclk, mosi, wait_out, access_out}),
                      64'({1'b1, cp, 1'b0, 1'b0, 1'b0}));
                spi_en = 1'b1;
                pulses = 0;
                repeat (40) begin
                    @(negedge clk);
                    if (access_out) pulses++;
                end
                check("abort_nopulse", 64'(pulses), 64'd0);
                check("abort_rx_hold", rx_data, last_rx);
                return;
            end
            if (mode == 2 && cyc == at) begin
                nreset = 1'b0;
                #1;
                check("rst_mid_pins", 64'({ss, sclk, mosi, wait_out, access_out}), 64'(5'b10000));
                check("rst_mid_rx", rx_data, 64'd0);
                @(negedge clk);
                nreset  = 1'b1;
                last_rx = '0;
                @(negedge clk);
                check("rst_mid_idle", 64'({ss, wait_out, sclk}), 64'({1'b1, 1'b0, cp}));
                return;
            end
            access_in = (mode == 3 && cyc == at);
            if (mode == 3 && cyc == at) tx_size = 4'd1;
            @(negedge clk);
            cyc++;
        end
        access_in = 1'b0;
        exp_rx = '0;
`ifdef SPI_MASTER_RX_EN
        exp_rx = (loop ? tx : sd) & byte_mask(n);
`endif
        check("latency", 64'(cyc), 64'(lat));
        check("wait_lo", 64'(wait_out), 64'd0);
        check("rx_data", rx_data, exp_rx);
        check("sclk_edges", 64'(s_edges), 64'(16 * n));
        check("mosi_bits", s_got, tx & byte_mask(n));
        last_rx = exp_rx;
        @(negedge clk);
        check("after_done", 64'({access_out, ss, sclk, wait_out}), 64'({1'b0, 1'b1, cp, 1'b0}));
        check("rx_hold", rx_data, exp_rx);
    endtask

    task automatic bad_req(input logic [3:0] sz);
        int act;
        @(negedge clk);
        tx_size = sz; tx_data = {$urandom, $urandom}; access_in = 1'b1;
        @(negedge clk);
        access_in = 1'b0;
        act = 0;
        repeat (30) begin
            if (!ss || wait_out || access_out) act++;
            @(negedge clk);
        end
        check("bad_size", 64'(act), 64'd0);
    endtask

    initial begin
        nreset = 1'b0; spi_en = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfirst = 1'b0;
        access_in = 1'b0; loopback = 1'b0; clkdiv = '0; tx_data = '0; tx_size = '0;
        s_cpha = 1'b0; s_lsb = 1'b0; s_n = 1; s_data = '0;
        repeat (3) @(negedge clk);
        check("rst_pins", 64'({ss, sclk, mosi, wait_out, access_out}), 64'(5'b10000));
        check("rst_rx", rx_data, 64'd0);
        nreset = 1'b1;
        cpol   = 1'b1;
        @(negedge clk);
        check("idle_cpol1", 64'(sclk), 64'd1);
        cpol = 1'b0;
        @(negedge clk);
        check("idle_cpol0", 64'(sclk), 64'd0);

        // Mode 0, msb first, loopback of 0xA5.
        xfer(1'b0, 1'b0, 1'b0, 8'd1, 1, 64'hA5, 64'h0, 1'b1, 0, 0);
        // Mode 3, lsb first, slave answers 0xBEEF.
        xfer(1'b1, 1'b1, 1'b1, 8'd3, 2, 64'h1234, 64'hBEEF, 1'b0, 0, 0);
        // Full-width transfer with an ignored mid-flight request, then an immediate re-issue.
        xfer(1'b0, 1'b0, 1'b0, 8'd0, 8, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 3, 50);
        xfer(1'b1, 1'b0, 1'b1, 8'd0, 8, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 0, 0);
        // spi_en dropped inside byte index 2.
        xfer(1'b0, 1'b1, 1'b0, 8'd1, 4, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1, 77);
        bad_req(4'd0);
        bad_req(4'd9);
        bad_req(4'd15);
        // Largest divider.
        xfer(1'b1, 1'b1, 1'b0, 8'd255, 1, 64'h3C, 64'hC3, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            xfer(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)),
                 int'($urandom_range(1, 8)), {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom), 0, 0);
        end
        // Reset in the middle of SHIFT, then a clean transfer.
        xfer(1'b0, 1'b0, 1'b1, 8'd0, 2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 2, 12);
        xfer(1'b0, 1'b1, 1'b1, 8'd2, 3, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
